sysid_ext_slave: RTL and testbench

//  Next-generation system-ID Avalon-MM slave: read-only ID/timestamp/version words plus

---
 rtl/sysid_ext_pkg.sv | 35 +++
 rtl/sysid_uptime_counter.sv | 40 ++++
 rtl/sysid_ext_slave.sv | 87 ++++++++
 tb/tb_sysid_ext_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sysid_ext_pkg.sv
// Shared register map, CTRL bit layout and byte-lane helper for the system-ID slave.
package sysid_ext_pkg;

  localparam logic [2:0] ADDR_SYSID     = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_VERSION   = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] ADDR_CTRL      = 3'd6;
  localparam logic [2:0] ADDR_RDCOUNT   = 3'd7;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam logic [31:0] CTRL_RST     = 32'h0000_0001;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  function automatic logic [31:0] merge_be(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with a shadow of the upper word, latched when the
// low word is read so a LO/HI read pair is coherent across a carry.
module sysid_uptime_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt,
  output logic [31:0]      shadow
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-33:0] shadow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      // clear beats increment when both land on the same edge
      if (clr)     cnt_q <= '0;
      else if (en) cnt_q <= cnt_q + ONE;
      if (clr)       shadow_q <= '0;
      else if (snap) shadow_q <= cnt_q[CNT_W-1:32];
    end
  end

  always_comb begin
    shadow              = '0;
    shadow[CNT_W-33:0]  = shadow_q;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sysid_ext_slave.sv
// System-ID Avalon-MM slave: ID/version words, scratch, CTRL, uptime with
// coherent 64-bit snapshot and a read-access counter; fixed 1-cycle read latency.
module sysid_ext_slave
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h50C0_0001,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  bus_req_t         req;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      shadow;
  logic [31:0]      scratch;
  logic [31:0]      rdcount;
  logic [31:0]      rdata;
  logic             ctrl_en;
  logic             wr_ok;
  logic             clr;
  logic             snap;

  assign req = '{read: read, write: write, addr: address, wdata: writedata, be: byteenable};

  // a read in the same cycle as a write wins; the write is dropped
  assign wr_ok = req.write & ~req.read;
  assign clr   = wr_ok & (req.addr == ADDR_CTRL) & req.be[0] & req.wdata[CTRL_CLR_BIT];
  assign snap  = req.read & (req.addr == ADDR_UPTIME_LO);

  sysid_uptime_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (ctrl_en),
    .clr     (clr),
    .snap    (snap),
    .cnt     (cnt),
    .shadow  (shadow)
  );

  always_comb begin
    rdata = '0;
    case (req.addr)
      ADDR_SYSID:     rdata = SYSTEM_ID;
      ADDR_TIMESTAMP: rdata = TIMESTAMP;
      ADDR_VERSION:   rdata = VERSION;
      ADDR_SCRATCH:   rdata = scratch;
      ADDR_UPTIME_LO: rdata = cnt[31:0];
      ADDR_UPTIME_HI: rdata = shadow;
      ADDR_CTRL:      rdata = {31'b0, ctrl_en};
      ADDR_RDCOUNT:   rdata = rdcount;
      default:        rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      scratch       <= SCRATCH_RST;
      ctrl_en       <= CTRL_RST[CTRL_EN_BIT];
      rdcount       <= '0;
    end else begin
      readdatavalid <= req.read;
      if (req.read) begin
        readdata <= rdata;
        // captured data above sees the pre-increment count
        rdcount  <= rdcount + 32'd1;
      end
      if (wr_ok && req.addr == ADDR_SCRATCH)
        scratch <= merge_be(scratch, req.wdata, req.be);
      if (wr_ok && req.addr == ADDR_CTRL && req.be[0])
        ctrl_en <= req.wdata[CTRL_EN_BIT];
    end
  end

endmodule

// File: tb/tb_sysid_ext_slave.sv
// Bench for sysid_ext_slave: table of bus cycles plus hand sequences, read results
// checked through an expected-value queue popped on readdatavalid.
module tb_sysid_ext_slave;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_ext_slave dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic [2:0]  a;
  } sb_t;

  sb_t        sbq[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] hist = '0;
  vec_t       tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [2:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    sb_t e;
    @(negedge clock);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd) begin
      e.exp = exp; e.a = a;
      sbq.push_back(e);
    end
  endtask

  task automatic rd_(input logic [2:0] a, input logic [31:0] exp);
    cyc(1'b1, 1'b0, a, 32'd0, 4'd0, exp);
  endtask

  task automatic wr_(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b0, 1'b1, a, d, be, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    reset_n = 1'b0;
    sbq.delete();
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_valid", {31'b0, readdatavalid}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Scoreboard: every valid cycle pops one expected read
  always @(posedge clock) begin : mon
    sb_t e;
    #2;
    hist = {hist[6:0], readdatavalid};
    if (reset_n && readdatavalid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got readdata %h with no read outstanding", readdata);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("read_addr%0d", e.a), readdata, e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int v;
    //            rd    wr    a     wd             be       exp
    tbl[0]  = '{1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 4'b0101, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'd3, 32'h0,         4'b0000, 32'h00AD_00EF};
    tbl[2]  = '{1'b0, 1'b1, 3'd0, 32'h1234_5678, 4'b1111, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 32'h0,         4'b0000, 32'h50C0_0001};
    tbl[4]  = '{1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 3'd1, 32'h0,         4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'd3, 32'h1122_3344, 4'b1010, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 3'd3, 32'h0,         4'b0000, 32'h11AD_33EF};
    tbl[8]  = '{1'b1, 1'b1, 3'd3, 32'h1234_5678, 4'b1111, 32'h11AD_33EF};
    tbl[9]  = '{1'b1, 1'b0, 3'd3, 32'h0,         4'b0000, 32'h11AD_33EF};
    tbl[10] = '{1'b0, 1'b1, 3'd6, 32'hFFFF_FFFC, 4'b1111, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'd6, 32'h0,         4'b0000, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'd6, 32'h0,         4'b0000, 32'h1};
    tbl[14] = '{1'b0, 1'b1, 3'd7, 32'h0,         4'b1111, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 3'd7, 32'h0,         4'b0000, 32'd11};
    tbl[16] = '{1'b0, 1'b1, 3'd6, 32'h0,         4'b1110, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 3'd6, 32'h0,         4'b0000, 32'h1};

    // ID words back-to-back after reset
    do_reset();
    rd_(3'd0, 32'h50C0_0001);
    rd_(3'd1, 32'h0);
    rd_(3'd2, 32'h0001_0000);
    idle(1);
    chk("valid_3_consecutive", {28'b0, hist[3:0]}, 32'h7);

    for (int i = 0; i < 18; i++)
      cyc(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].exp);
    idle(1);

    // Carry from low to high word between LO and HI reads
    wr_(3'd6, 32'h0, 4'hF);
    idle(1);
    force dut.u_cnt.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_cnt.cnt_q;
    wr_(3'd6, 32'h1, 4'hF);
    rd_(3'd4, 32'hFFFF_FFFF);
    rd_(3'd5, 32'h0);
    rd_(3'd4, 32'h1);
    rd_(3'd5, 32'h1);
    idle(1);

    // EN off holds the count; CLR clears shadow and beats increment
    wr_(3'd6, 32'h2, 4'hF);
    idle(10);
    rd_(3'd5, 32'h0);
    rd_(3'd4, 32'h0);
    wr_(3'd6, 32'h3, 4'hF);
    rd_(3'd4, 32'h0);
    idle(5);
    wr_(3'd6, 32'h3, 4'hF);
    rd_(3'd4, 32'h0);
    rd_(3'd6, 32'h1);
    rd_(3'd4, 32'h2);
    rd_(3'd5, 32'h0);
    idle(1);

    // RDCOUNT returns pre-increment value
    do_reset();
    repeat (4) rd_(3'd0, 32'h50C0_0001);
    rd_(3'd7, 32'd4);
    wr_(3'd3, 32'hAAAA_5555, 4'hF);
    wr_(3'd6, 32'h0, 4'hF);

    // Reset lands while a read result is on the bus and another is issued
    rd_(3'd0, 32'h50C0_0001);
    @(negedge clock);
    read = 1'b1; address = 3'd2;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    read = 1'b0;
    sbq.delete();
    #2;
    chk("midrst_valid", {31'b0, readdatavalid}, 32'd0);
    chk("midrst_readdata", readdata, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    v = 0;
    repeat (4) begin
      @(posedge clock);
      #2;
      if (readdatavalid) v++;
    end
    chk("no_valid_after_release", 32'(v), 32'd0);
    rd_(3'd7, 32'd0);
    rd_(3'd3, 32'h0);
    rd_(3'd6, 32'h1);
    rd_(3'd5, 32'h0);
    idle(3);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
